// File: rtl/comb_sweep_ctrl.sv
// comb_sweep_ctrl -- sweeps all 8 input vectors of the three-input block
// comb_complex, waits SETTLE_CYCLES per vector, captures b4 into a truth
// table and compares it against an expected table latched at start.
//
// Ports:
//   clk_i, rst_ni         clock (rising edge), synchronous active-low reset
//   start_i, abort_i      sweep request (IDLE only) / terminate sweep
//   exp_tt_i[7:0]         expected truth table, latched on start accept
//   b1_o, b2_o, b3_o      registered vector drive (v[0], v[1], v[2])
//   b4_i                  response from comb_complex
//   busy_o                high outside IDLE
//   done_o                one-cycle completion pulse
//   pass_o                captured table equals expected
//   tt_o[7:0]             captured truth table
//   mism_o[7:0]           captured XOR expected
//   err_cnt_o[3:0]        mismatch count (only with SWEEP_ERRCNT_EN)
//
// Optional build macro: SWEEP_ERRCNT_EN adds err_cnt_o.
//
// state  | meaning
// IDLE   | waiting for start, drives 0
// DRIVE  | vector v applied, settle counter running
// SAMPLE | capture b4 into tt[v], advance or finish
// DONE   | done pulse, return to IDLE
module comb_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [7:0] exp_tt_i,
  output logic       b1_o,
  output logic       b2_o,
  output logic       b3_o,
  input  logic       b4_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [7:0] tt_o,
  output logic [7:0] mism_o
`ifdef SWEEP_ERRCNT_EN
  ,
  output logic [3:0] err_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

  state_t           state_q, state_d;
  logic             accept;
  logic [2:0]       v_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       exp_q;
  logic [7:0]       tt_q;
  logic [7:0]       tt_cap;
  logic [7:0]       mism_q;
  logic             pass_q;
  logic [3:0]       err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done_o  = 1'b0;
    busy_o  = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          accept  = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (abort_i)                    state_d = IDLE;
        else if (cnt_q == CNT_W'(1))    state_d = SAMPLE;
      end
      SAMPLE: begin
        if (abort_i)                    state_d = IDLE;
        else if (v_q == 3'd7)           state_d = DONE;
        else                            state_d = DRIVE;
      end
      DONE: begin
        // Pulse is combinational so a coincident abort can suppress it.
        done_o  = !abort_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Truth table including this cycle's sample, so the final compare is
  // already valid while done_o is high.
  always_comb begin
    tt_cap      = tt_q;
    tt_cap[v_q] = b4_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v_q    <= '0;
      cnt_q  <= '0;
      exp_q  <= '0;
      tt_q   <= '0;
      mism_q <= '0;
      pass_q <= 1'b0;
      err_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            exp_q  <= exp_tt_i;
            tt_q   <= '0;
            mism_q <= '0;
            pass_q <= 1'b0;
            err_q  <= '0;
            v_q    <= '0;
            cnt_q  <= SETTLE_LD;
          end
        end
        DRIVE: begin
          if (abort_i) v_q   <= '0;
          else         cnt_q <= cnt_q - CNT_W'(1);
        end
        SAMPLE: begin
          if (abort_i) begin
            v_q <= '0;
          end else begin
            tt_q <= tt_cap;
            if (b4_i != exp_q[v_q]) err_q <= err_q + 4'd1;
            if (v_q == 3'd7) begin
              v_q    <= '0;
              pass_q <= (tt_cap == exp_q);
              mism_q <= tt_cap ^ exp_q;
            end else begin
              v_q   <= v_q + 3'd1;
              cnt_q <= SETTLE_LD;
            end
          end
        end
        DONE: begin
          v_q <= '0;
          if (abort_i) pass_q <= 1'b0;
        end
        default: v_q <= '0;
      endcase
    end
  end

  assign b1_o   = v_q[0];
  assign b2_o   = v_q[1];
  assign b3_o   = v_q[2];
  assign tt_o   = tt_q;
  assign mism_o = mism_q;
  assign pass_o = pass_q;

`ifdef SWEEP_ERRCNT_EN
  assign err_cnt_o = err_q;
`else
  logic unused_err;
  assign unused_err = ^err_q;
`endif

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
module tb_comb_sweep_ctrl;
  localparam int S1 = 1;
  localparam int S3 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // DUT with SETTLE_CYCLES=1
  logic       start = 0, abort = 0;
  logic [7:0] exp_tt = 0;
  logic       b1, b2, b3, b4;
  logic       busy, done, pass;
  logic [7:0] tt, mism;
  logic [7:0] lut = 0;
  logic [2:0] vec;
  assign vec = {b3, b2, b1};
  assign b4  = lut[vec];

  // DUT with SETTLE_CYCLES=3, response delayed by 2 cycles
  logic       start3 = 0, abort3 = 0;
  logic [7:0] exp_tt3 = 0;
  logic       b1_3, b2_3, b3_3, b4_3;
  logic       busy3, done3, pass3;
  logic [7:0] tt3, mism3;
  logic [7:0] lut3 = 0;
  logic [1:0] dly;
  always @(posedge clk) begin
    if (!rst_n) dly <= 2'b00;
    else        dly <= {dly[0], lut3[{b3_3, b2_3, b1_3}]};
  end
  assign b4_3 = dly[1];

`ifdef SWEEP_ERRCNT_EN
  logic [3:0] err_cnt, err_cnt3;
`endif

  comb_sweep_ctrl #(.SETTLE_CYCLES(S1), .CNT_W(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .exp_tt_i(exp_tt), .b1_o(b1), .b2_o(b2), .b3_o(b3), .b4_i(b4),
    .busy_o(busy), .done_o(done), .pass_o(pass), .tt_o(tt), .mism_o(mism)
`ifdef SWEEP_ERRCNT_EN
    , .err_cnt_o(err_cnt)
`endif
  );

  comb_sweep_ctrl #(.SETTLE_CYCLES(S3), .CNT_W(4)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start3), .abort_i(abort3),
    .exp_tt_i(exp_tt3), .b1_o(b1_3), .b2_o(b2_3), .b3_o(b3_3), .b4_i(b4_3),
    .busy_o(busy3), .done_o(done3), .pass_o(pass3), .tt_o(tt3), .mism_o(mism3)
`ifdef SWEEP_ERRCNT_EN
    , .err_cnt_o(err_cnt3)
`endif
  );

  // b4 = (b1 & b2) | b3 as a truth table
  function automatic logic [7:0] formula_tt();
    logic [7:0] t;
    logic [2:0] v;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      v    = 3'(i);
      t[i] = (v[0] & v[1]) | v[2];
    end
    return t;
  endfunction

  // Runs one sweep on u_dut; records done timing and vector sequence errors.
  task automatic do_sweep1(input logic [7:0] f, input logic [7:0] e,
                           output int done_at, output int done_cnt, output int vec_err);
    lut = f;
    @(posedge clk); #1;
    exp_tt = e; start = 1;
    @(posedge clk); #1;
    start = 0; exp_tt = 8'($urandom);
    done_at = -1; done_cnt = 0; vec_err = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c <= 8*(S1+1) && vec != 3'((c-1)/(S1+1))) vec_err++;
      if (c >= 8*(S1+1)+2 && (vec != 3'd0 || busy)) vec_err++;
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || vec !== 3'd0 || tt !== 8'h00 || pass !== 1'b0 || mism !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b done=%b vec=%0d tt=%h pass=%b mism=%h, required all 0", busy, done, vec, tt, pass, mism);
    end
    n_tests++;
    if (busy3 !== 1'b0 || done3 !== 1'b0 || tt3 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_idle3: busy=%b done=%b tt=%h, required 0", busy3, done3, tt3);
    end
    // reset in the middle of a sweep
    lut = 8'hFF;
    @(posedge clk); #1 exp_tt = 8'h00; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (7) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || vec !== 3'd0 || tt !== 8'h00 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b vec=%0d tt=%h pass=%b, required all 0", busy, done, vec, tt, pass);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic check_sweep(input string name, input logic [7:0] f, input logic [7:0] e);
    int done_at, done_cnt, vec_err;
    do_sweep1(f, e, done_at, done_cnt, vec_err);
    n_tests++;
    if (done_at != 1 + 8*(S1+1) || done_cnt != 1) begin
      n_fail++;
      $display("FAIL %s_done: at=%0d count=%0d, required at=%0d count=1", name, done_at, done_cnt, 1 + 8*(S1+1));
    end
    n_tests++;
    if (vec_err != 0) begin
      n_fail++;
      $display("FAIL %s_vectors: %0d wrong cycles, required 0", name, vec_err);
    end
    n_tests++;
    if (tt !== f || mism !== (f ^ e) || pass !== (f == e)) begin
      n_fail++;
      $display("FAIL %s_result: tt=%h mism=%h pass=%b, required tt=%h mism=%h pass=%b", name, tt, mism, pass, f, f ^ e, f == e);
    end
`ifdef SWEEP_ERRCNT_EN
    n_tests++;
    if (err_cnt !== 4'($countones(f ^ e))) begin
      n_fail++;
      $display("FAIL %s_errcnt: %0d, required %0d", name, err_cnt, $countones(f ^ e));
    end
`endif
  endtask

  task automatic test_good();
    check_sweep("good", formula_tt(), formula_tt());
  endtask

  task automatic test_mismatch();
    logic [7:0] e;
    e = formula_tt();
    e[4] = ~e[4];
    check_sweep("mismatch", formula_tt(), e);
    n_tests++;
    if (mism !== 8'h10) begin
      n_fail++;
      $display("FAIL mismatch_map: mism=%h, required 10", mism);
    end
  endtask

  task automatic test_random();
    logic [7:0] f, e;
    for (int i = 0; i < 6; i++) begin
      f = 8'($urandom);
      e = ($urandom_range(0, 2) == 0) ? f : 8'($urandom);
      check_sweep("random", f, e);
    end
  endtask

  task automatic abort_at(input int k, input logic [7:0] f, input logic [7:0] e);
    logic [7:0] mask;
    bit found;
    int dcnt;
    mask = 8'((1 << k) - 1);
    lut = f;
    @(posedge clk); #1 exp_tt = e; start = 1;
    @(posedge clk); #1 start = 0;
    found = 0; dcnt = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (busy && vec == 3'(k)) begin
        found = 1;
        abort = 1;
      end
    end
    @(negedge clk);
    abort = 0;
    n_tests++;
    if (!found || busy !== 1'b0 || vec !== 3'd0 || tt !== (f & mask) || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_v%0d: found=%b busy=%b vec=%0d tt=%h pass=%b, required busy=0 vec=0 tt=%h pass=0", k, found, busy, vec, tt, pass, f & mask);
    end
`ifdef SWEEP_ERRCNT_EN
    n_tests++;
    if (err_cnt !== 4'($countones((f ^ e) & mask))) begin
      n_fail++;
      $display("FAIL abort_errcnt: %0d, required %0d", err_cnt, $countones((f ^ e) & mask));
    end
`endif
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    n_tests++;
    if (dcnt != 0) begin
      n_fail++;
      $display("FAIL abort_nodone: %0d done/busy cycles, required 0", dcnt);
    end
  endtask

  task automatic test_abort();
    abort_at(3, formula_tt(), formula_tt());
    for (int i = 0; i < 3; i++) abort_at($urandom_range(0, 7), 8'($urandom), 8'($urandom));
  endtask

  task automatic test_busy_start();
    int done_at, dcnt;
    bit poked;
    lut = formula_tt();
    @(posedge clk); #1 exp_tt = formula_tt(); start = 1;
    @(posedge clk); #1 start = 0;
    done_at = -1; dcnt = 0; poked = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = 0;
      if (done) begin
        dcnt++;
        if (done_at < 0) done_at = c;
      end
      if (!poked && vec == 3'd5) begin
        poked = 1;
        start = 1;
      end
    end
    start = 0;
    n_tests++;
    if (done_at != 1 + 8*(S1+1) || dcnt != 1 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start: done_at=%0d count=%0d pass=%b, required %0d 1 1", done_at, dcnt, pass, 1 + 8*(S1+1));
    end
    @(posedge clk); #1 start = 1; abort = 1;
    @(posedge clk); #1 start = 0; abort = 0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || tt !== formula_tt() || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL start_abort_idle: busy=%b tt=%h pass=%b, required busy=0 tt=%h pass=1", busy, tt, pass, formula_tt());
    end
  endtask

  task automatic test_abort_done();
    int dcnt;
    lut = 8'h5A;
    @(posedge clk); #1 exp_tt = 8'h5A; start = 1;
    @(posedge clk); #1 start = 0;
    dcnt = 0;
    for (int c = 1; c <= 8*(S1+1); c++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    @(posedge clk); #1 abort = 1;
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_done_pulse: done=%b busy=%b, required done=0 busy=1", done, busy);
    end
    @(posedge clk); #1 abort = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    n_tests++;
    if (dcnt != 0 || busy !== 1'b0 || pass !== 1'b0 || tt !== 8'h5A) begin
      n_fail++;
      $display("FAIL abort_done_state: dones=%0d busy=%b pass=%b tt=%h, required 0 0 0 5a", dcnt, busy, pass, tt);
    end
  endtask

  task automatic test_settle3();
    logic [7:0] f, e;
    int done_at, dcnt;
    for (int r = 0; r < 2; r++) begin
      f = (r == 0) ? formula_tt() : 8'($urandom);
      e = (r == 0) ? formula_tt() : 8'($urandom);
      lut3 = f;
      @(posedge clk); #1 exp_tt3 = e; start3 = 1;
      @(posedge clk); #1 start3 = 0; exp_tt3 = 8'($urandom);
      done_at = -1; dcnt = 0;
      for (int c = 1; c <= 45; c++) begin
        @(negedge clk);
        if (done3) begin
          dcnt++;
          if (done_at < 0) done_at = c;
        end
      end
      n_tests++;
      if (done_at != 1 + 8*(S3+1) || dcnt != 1) begin
        n_fail++;
        $display("FAIL settle3_done: at=%0d count=%0d, required at=%0d count=1", done_at, dcnt, 1 + 8*(S3+1));
      end
      n_tests++;
      if (tt3 !== f || mism3 !== (f ^ e) || pass3 !== (f == e)) begin
        n_fail++;
        $display("FAIL settle3_result: tt=%h mism=%h pass=%b, required tt=%h mism=%h pass=%b", tt3, mism3, pass3, f, f ^ e, f == e);
      end
`ifdef SWEEP_ERRCNT_EN
      n_tests++;
      if (err_cnt3 !== 4'($countones(f ^ e))) begin
        n_fail++;
        $display("FAIL settle3_errcnt: %0d, required %0d", err_cnt3, $countones(f ^ e));
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_mismatch();
    test_random();
    test_abort();
    test_busy_start();
    test_abort_done();
    test_settle3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
